// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, FSM states and alignment helper for the data-memory responder
package dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam int WAIT_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] size);
    return (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-enables/lane replication and load lane extraction with extension
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  assign be = size == SIZE_B ? 4'b0001 << addr_lo :
              size == SIZE_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_lanes = size == SIZE_B ? {4{wdata[7:0]}} :
                       size == SIZE_H ? {2{wdata[15:0]}} : wdata;
  assign b = 8'(mem_word >> {addr_lo, 3'b000});
  assign h = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  assign rdata = size == SIZE_B ? {{24{~zero_ext & b[7]}}, b} :
                 size == SIZE_H ? {{16{~zero_ext & h[15]}}, h} : mem_word;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data-memory slave with sized access and fault reporting; DMEM_STATS_EN adds access counters
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic        mem_write_en,
  input  logic        mem_read_en,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] data_read,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_faults
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  state_t state, state_n;
  logic [WAIT_CNT_W-1:0] cnt, cnt_n;
  logic [31:0] l_addr, l_wdata, a_addr, a_wdata, mem_word, wlanes, rdata, rdata_q;
  logic [1:0]  l_size, a_size;
  logic        l_uns, l_rd, l_wr, a_uns, a_rd, a_wr;
  logic        req, go, fault, fault_q, commit;
  logic [3:0]  be;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign req = mem_read_en | mem_write_en;
  // Zero-wait accesses resolve straight from the bus; waited ones from the latched copy
  assign {a_addr, a_wdata, a_size, a_uns, a_rd, a_wr} = state == IDLE ?
    {data_addr, data_write, mem_size, mem_unsigned, mem_read_en, mem_write_en} :
    {l_addr, l_wdata, l_size, l_uns, l_rd, l_wr};
  assign idx = a_addr[ADDR_WIDTH+1:2];
  assign mem_word = mem[idx];
  assign fault = (a_rd & a_wr) | (a_size == 2'b11) | misaligned(a_addr[1:0], a_size) |
                 ((a_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign commit = go & ~fault & a_wr & reset_n;
  dmem_lane_align u_align (
    .addr_lo(a_addr[1:0]), .size(a_size), .zero_ext(a_uns), .wdata(a_wdata),
    .mem_word(mem_word), .be(be), .wdata_lanes(wlanes), .rdata(rdata)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    go = 1'b0;
    case (state)
      IDLE: if (req) begin
        cnt_n = mem_read_en ? WAIT_CNT_W'(READ_WAIT) : WAIT_CNT_W'(WRITE_WAIT);
        go = cnt_n == '0;
        state_n = go ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        go = cnt_n == '0;
        state_n = go ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      {l_addr, l_wdata, l_size, l_uns, l_rd, l_wr} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req)
        {l_addr, l_wdata, l_size, l_uns, l_rd, l_wr} <=
          {data_addr, data_write, mem_size, mem_unsigned, mem_read_en, mem_write_en};
      if (go) begin
        fault_q <= fault;
        rdata_q <= (fault | a_wr) ? '0 : rdata;
      end
    end
  always_ff @(posedge clk)
    if (commit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
  assign mem_ready = state == RESP;
  assign mem_fault = mem_ready & fault_q;
  assign data_read = rdata_q;
`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_reads <= '0;
      stat_writes <= '0;
      stat_faults <= '0;
    end else if (mem_ready) begin
      if (fault_q) stat_faults <= stat_faults + 1'b1;
      else if (l_wr) stat_writes <= stat_writes + 1'b1;
      else stat_reads <= stat_reads + 1'b1;
    end
`else
  assign stat_reads = '0;
  assign stat_writes = '0;
  assign stat_faults = '0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus random accesses checked against a word-array memory model
module tb_data_mem_responder;
  localparam int AW = 10, RW = 1, WW = 3, DEPTH = 1 << AW;
  logic clk = 0, reset_n = 0;
  logic [31:0] data_addr = 0, data_write = 0;
  logic mem_write_en = 0, mem_read_en = 0, mem_unsigned = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] data_read, stat_reads, stat_writes, stat_faults;
  logic mem_ready, mem_fault;
  int checks = 0, errors = 0, n_rd = 0, n_wr = 0, n_ft = 0;
  logic [31:0] mm [DEPTH];
  logic [31:0] last_data;
  data_mem_responder #(.ADDR_WIDTH(AW), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .reset_n(reset_n), .data_addr(data_addr), .data_write(data_write),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .data_read(data_read), .mem_ready(mem_ready),
    .mem_fault(mem_fault), .stat_reads(stat_reads), .stat_writes(stat_writes),
    .stat_faults(stat_faults)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic model_fault(logic rd, logic wr, logic [1:0] sz, logic [31:0] a);
    return (rd && wr) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || a >= 32'(4 * DEPTH);
  endfunction
  function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic uns);
    logic [31:0] w, v;
    w = mm[a[AW+1:2]];
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction
  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    sh = sz == 2'd0 ? 8 * int'(a % 4) : sz == 2'd1 ? 16 * int'((a / 2) % 2) : 0;
    m = sz == 2'd0 ? 32'hFF << sh : sz == 2'd1 ? 32'hFFFF << sh : 32'hFFFFFFFF;
    mm[a[AW+1:2]] = (mm[a[AW+1:2]] & ~m) | ((d << sh) & m);
  endtask
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic ef, seen;
    logic [31:0] ed;
    int n, lat;
    ef = model_fault(rd, wr, sz, a);
    ed = (ef || wr) ? 32'd0 : model_load(a, sz, uns);
    lat = 1 + (rd ? RW : WW);
    @(negedge clk);
    data_addr = a; data_write = d; mem_size = sz; mem_unsigned = uns;
    mem_read_en = rd; mem_write_en = wr;
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      seen = mem_ready;
    end
    mem_read_en = 0; mem_write_en = 0;
    last_data = data_read;
    check({tag, "_ready"}, 32'(seen), 32'd1);
    if (rd ^ wr) check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_fault"}, 32'(mem_fault), 32'(ef));
    check({tag, "_data"}, data_read, ed);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(mem_ready), 32'd0);
    if (ef) n_ft++;
    else if (wr) begin n_wr++; model_store(a, sz, d); end
    else n_rd++;
  endtask
  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, "_reads"}, stat_reads, 32'(n_rd));
    check({tag, "_writes"}, stat_writes, 32'(n_wr));
    check({tag, "_faults"}, stat_faults, 32'(n_ft));
`else
    check({tag, "_reads"}, stat_reads, 32'd0);
    check({tag, "_writes"}, stat_writes, 32'd0);
    check({tag, "_faults"}, stat_faults, 32'd0);
`endif
  endtask
  initial begin
    logic rd, wr;
    logic [31:0] a;
    int k;
    #1;
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_data", data_read, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    access(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, "st_w");
    access(1, 0, 2'd2, 0, 32'h100, 32'h0, "ld_w");
    check("plan_beef", last_data, 32'hDEADBEEF);
    access(0, 1, 2'd2, 0, 32'h200, 32'h11223344, "st_w2");
    access(0, 1, 2'd0, 0, 32'h202, 32'h000000AA, "st_b");
    access(1, 0, 2'd2, 0, 32'h200, 32'h0, "ld_w2");
    check("plan_merge", last_data, 32'h11AA3344);
    access(1, 0, 2'd0, 0, 32'h202, 32'h0, "ld_bs");
    check("plan_bs", last_data, 32'hFFFFFFAA);
    access(1, 0, 2'd0, 1, 32'h202, 32'h0, "ld_bu");
    check("plan_bu", last_data, 32'h000000AA);
    access(0, 1, 2'd1, 0, 32'h206, 32'h00008001, "st_h");
    access(1, 0, 2'd1, 0, 32'h206, 32'h0, "ld_hs");
    check("plan_hs", last_data, 32'hFFFF8001);
    access(1, 0, 2'd1, 1, 32'h206, 32'h0, "ld_hu");
    check("plan_hu", last_data, 32'h00008001);
    access(1, 0, 2'd2, 0, 32'h102, 32'h0, "f_ld_mis");
    access(0, 1, 2'd1, 0, 32'h101, 32'hFFFF, "f_st_mis");
    access(0, 1, 2'd2, 0, 32'h0, 32'h55, "st_0");
    access(0, 1, 2'd2, 0, 32'h1000, 32'h99, "f_range");
    access(1, 1, 2'd2, 0, 32'h100, 32'h1234, "f_both");
    access(1, 0, 2'd2, 0, 32'h100, 32'h0, "ld_100");
    check("plan_keep100", last_data, 32'hDEADBEEF);
    access(1, 0, 2'd2, 0, 32'h0, 32'h0, "ld_0");
    check("plan_keep0", last_data, 32'h55);
    access(0, 1, 2'd2, 0, 32'h300, 32'h12345678, "st_300");
    access(1, 0, 2'd2, 0, 32'h300, 32'h0, "ld_300a");
    @(negedge clk);
    data_addr = 32'h300; data_write = 32'hCAFEF00D; mem_size = 2'd2;
    mem_write_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    check("wait_ready", 32'(mem_ready), 32'd0);
    reset_n = 0;
    #1;
    check("arst_ready", 32'(mem_ready), 32'd0);
    check("arst_fault", 32'(mem_fault), 32'd0);
    check("arst_data", data_read, 32'd0);
    mem_write_en = 0;
    @(posedge clk);
    @(negedge clk) reset_n = 1;
    n_rd = 0; n_wr = 0; n_ft = 0;
    check_stats("st_rst");
    access(1, 0, 2'd2, 0, 32'h300, 32'h0, "ld_300b");
    check("plan_old300", last_data, 32'h12345678);
    access(0, 1, 2'd2, 0, 32'h304, 32'hA5A5A5A5, "st_304");
    access(0, 1, 2'd0, 0, 32'h305, 32'h3C, "st_305");
    access(1, 0, 2'd2, 0, 32'h304, 32'h0, "ld_304");
    access(1, 0, 2'd0, 1, 32'h305, 32'h0, "ld_305");
    access(1, 0, 2'd3, 0, 32'h304, 32'h0, "f_size");
    check_stats("st_mix");
    for (int i = 0; i < 8; i++) access(0, 1, 2'd2, 0, 32'h400 + 32'(4 * i), $urandom, "init");
    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 19));
      rd = k < 9 || k >= 18;
      wr = k >= 9;
      a = 32'h400 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = a ^ 32'h0001_0000;
      access(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end
    check_stats("st_end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
